// File: rtl/nn_pkg.sv
// +--------------------------------------------------------------------+
// | nn_pkg : shared types, default widths and shift/saturate helper     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package nn_pkg;

   localparam int DEF_NUM_INPUTS  = 784;
   localparam int DEF_NUM_OUTPUTS = 10;
   localparam int DEF_PIX_W       = 16;
   localparam int DEF_WGT_W       = 16;
   localparam int DEF_RES_W       = 17;
   localparam int DEF_FRAC_BITS   = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Works on a 64-bit carrier so one helper serves every accumulator/result width.
   function automatic logic signed [63:0] sat_signed(
      input  logic signed [63:0] val,
      input  int                 shift,
      input  int                 res_w,
      output logic               clipped
   );
      logic signed [63:0] sh;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sh      = val >>> shift;
      hi      = (64'sd1 <<< (res_w - 1)) - 64'sd1;
      lo      = -hi - 64'sd1;
      clipped = 1'b0;
      if (sh > hi) begin
         clipped = 1'b1;
         return hi;
      end else if (sh < lo) begin
         clipped = 1'b1;
         return lo;
      end
      return sh;
   endfunction

endpackage

`default_nettype wire

// File: rtl/nn_mac.sv
// +--------------------------------------------------------------------+
// | nn_mac : signed multiply-accumulate with clear and enable           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module nn_mac #(
   parameter int PIX_W = 16,
   parameter int WGT_W = 16,
   parameter int ACC_W = 42
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [PIX_W-1:0] pix,
   input  logic [WGT_W-1:0] wgt,
   output logic [ACC_W-1:0] acc_next
);

   localparam int PROD_W = PIX_W + WGT_W;

   logic [PROD_W-1:0]        pix_x;
   logic [PROD_W-1:0]        wgt_x;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc;

   // Operands are widened to the product width so the multiply is exact.
   assign pix_x    = {{WGT_W{pix[PIX_W-1]}}, pix};
   assign wgt_x    = {{PIX_W{wgt[WGT_W-1]}}, wgt};
   assign prod     = $signed(pix_x) * $signed(wgt_x);
   assign acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/nn_layer_engine.sv
// +--------------------------------------------------------------------+
// | nn_layer_engine : fully-connected layer with scaling, ReLU, argmax  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module nn_layer_engine
   import nn_pkg::*;
#(
   parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
   parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
   parameter int PIX_W       = DEF_PIX_W,
   parameter int WGT_W       = DEF_WGT_W,
   parameter int RES_W       = DEF_RES_W,
   parameter int FRAC_BITS   = DEF_FRAC_BITS
)(
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start,
   input  logic                                     relu_en,
   output logic [$clog2(NUM_INPUTS)-1:0]            pix_addr,
   input  logic [PIX_W-1:0]                         pix_rdata,
   output logic [$clog2(NUM_INPUTS*NUM_OUTPUTS)-1:0] wgt_addr,
   input  logic [WGT_W-1:0]                         wgt_rdata,
   output logic                                     res_we,
   output logic [$clog2(NUM_OUTPUTS)-1:0]           res_sel,
   output logic [RES_W-1:0]                         res_data,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     overflow,
   output logic [$clog2(NUM_OUTPUTS)-1:0]           argmax,
   output logic [RES_W-1:0]                         max_value
);

   localparam int IN_W  = $clog2(NUM_INPUTS);
   localparam int OUT_W = $clog2(NUM_OUTPUTS);
   localparam int WA_W  = $clog2(NUM_INPUTS*NUM_OUTPUTS);
   localparam int ACC_W = PIX_W + WGT_W + IN_W;

   localparam logic [IN_W-1:0]  LAST_I = IN_W'(NUM_INPUTS - 1);
   localparam logic [OUT_W-1:0] LAST_N = OUT_W'(NUM_OUTPUTS - 1);

   state_t             state;
   logic [OUT_W-1:0]   n;
   logic               relu_r;
   logic               rd_valid;
   logic               mac_clr;
   logic [ACC_W-1:0]   acc_next;
   logic signed [63:0] acc_ext;
   logic signed [63:0] sat_val;
   logic signed [63:0] res_next;
   logic signed [63:0] max_ext;
   logic               sat_clip;
   logic               better;

   assign mac_clr = (state == ST_WRITE) || ((state == ST_IDLE) && start);

   nn_mac #(
      .PIX_W (PIX_W),
      .WGT_W (WGT_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .clr      (mac_clr),
      .en       (rd_valid),
      .pix      (pix_rdata),
      .wgt      (wgt_rdata),
      .acc_next (acc_next)
   );

   // During DRAIN acc_next already holds the complete dot product.
   assign acc_ext = {{(64-ACC_W){acc_next[ACC_W-1]}}, acc_next};
   assign max_ext = {{(64-RES_W){max_value[RES_W-1]}}, max_value};

   always_comb begin
      sat_clip = 1'b0;
      sat_val  = sat_signed(acc_ext, FRAC_BITS, RES_W, sat_clip);
      res_next = (relu_r && sat_val[63]) ? 64'sd0 : sat_val;
      better   = (n == '0) || (res_next > max_ext);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         n         <= '0;
         relu_r    <= 1'b0;
         rd_valid  <= 1'b0;
         pix_addr  <= '0;
         wgt_addr  <= '0;
         res_we    <= 1'b0;
         res_sel   <= '0;
         res_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
         argmax    <= '0;
         max_value <= '0;
      end else begin
         res_we   <= 1'b0;
         done     <= 1'b0;
         rd_valid <= (state == ST_RUN);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  relu_r    <= relu_en;
                  n         <= '0;
                  pix_addr  <= '0;
                  wgt_addr  <= '0;
                  overflow  <= 1'b0;
                  argmax    <= '0;
                  max_value <= '0;
                  busy      <= 1'b1;
                  state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (pix_addr == LAST_I) begin
                  state <= ST_DRAIN;
               end else begin
                  pix_addr <= pix_addr + IN_W'(1);
                  wgt_addr <= wgt_addr + WA_W'(1);
               end
            end
            ST_DRAIN: begin
               res_we   <= 1'b1;
               res_sel  <= n;
               res_data <= res_next[RES_W-1:0];
               if (sat_clip) begin
                  overflow <= 1'b1;
               end
               // Strict compare keeps the lower index on ties.
               if (better) begin
                  argmax    <= n;
                  max_value <= res_next[RES_W-1:0];
               end
               state <= ST_WRITE;
            end
            ST_WRITE: begin
               pix_addr <= '0;
               if (n == LAST_N) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  n        <= n + OUT_W'(1);
                  wgt_addr <= wgt_addr + WA_W'(1);
                  state    <= ST_RUN;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/nn_layer_engine.md
# nn_layer_engine

Parametrised fully-connected layer engine: computes NUM_OUTPUTS dot products of a NUM_INPUTS pixel vector with row-major weight rows. It reads both operands from synchronous-read memories, then scales, saturates and optionally ReLU-clips each result. Each result is written to the result register bank, and the argmax across outputs is tracked. It sits between the Avalon interface (start/done) and the pixel/weight memories, replacing the fixed-size multiplier plus main controller pair with a single block.

## Interface
- NUM_INPUTS, 784, pixels per input vector (>=2)
- NUM_OUTPUTS, 10, neurons (>=2)
- PIX_W, 16, signed pixel width
- WGT_W, 16, signed weight width
- RES_W, 17, signed result width
- FRAC_BITS, 8, arithmetic right shift applied to accumulator before saturation
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a layer computation; sampled only in IDLE
- relu_en  in  1  sampled with start; clip negative results to 0 for the whole run
- pix_addr  out  $clog2(NUM_INPUTS)  pixel memory read address
- pix_rdata  in  PIX_W  signed pixel, valid one cycle after its address
- wgt_addr  out  $clog2(NUM_INPUTS*NUM_OUTPUTS)  weight address = neuron*NUM_INPUTS + i
- wgt_rdata  in  WGT_W  signed weight, valid one cycle after its address
- res_we  out  1  result register write strobe
- res_sel  out  $clog2(NUM_OUTPUTS)  result register index
- res_data  out  RES_W  final neuron value
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of run
- overflow  out  1  sticky: any neuron saturated in the current/last run
- argmax  out  $clog2(NUM_OUTPUTS)  index of largest written result
- max_value  out  RES_W  value at argmax

## Operation
- FSM states: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE:
  - start=1: latch relu_en, clear neuron counter n, input counter i, accumulator, overflow, argmax and max_value.
  - Go to RUN.
- RUN: present pix_addr=i, wgt_addr=n*NUM_INPUTS+i. Accumulate the product of data returned for address i-1 (none at i=0). At i=NUM_INPUTS-1 go to DRAIN; otherwise i++.
- DRAIN: accumulate the final product; no addresses consumed (addresses hold last value).
- WRITE:
  - res_we=1, res_sel=n.
  - res_data = sat_RES_W(acc >>> FRAC_BITS), then 0 if relu_en and negative.
  - Set overflow if saturation clipped.
  - If n==0 or res_data > max_value: update argmax=n, max_value=res_data. Ties keep the lower index.
  - Clear acc and i. If n==NUM_OUTPUTS-1 go to DONE, else n++ and go to RUN.
- DONE: done=1, go to IDLE.
- Accumulator width ACC_W = PIX_W+WGT_W+$clog2(NUM_INPUTS); it never wraps. Products and shifts are signed.
- start while busy is ignored; start and rst together: rst wins.
- rst mid-run: return to IDLE immediately, no further res_we, partial results abandoned.

## Timing
- Reset values: res_we=0, done=0, busy=0, overflow=0, argmax=0, max_value=0, res_data=0, res_sel=0, pix_addr=0, wgt_addr=0.
- start high at cycle 0 (IDLE): first RUN cycle is 1, busy rises at cycle 1.
- Per neuron: NUM_INPUTS RUN + 1 DRAIN + 1 WRITE cycles.
- done asserted at cycle NUM_OUTPUTS*(NUM_INPUTS+2)+1; busy low in that cycle.
- start may be reasserted the cycle after done; argmax, max_value and overflow hold until the next start.
- Memory read latency is exactly 1 cycle; no waitrequest or backpressure.

## Structure
- Package nn_pkg: state enum (IDLE, RUN, DRAIN, WRITE, DONE), sat_signed function (shift + saturate), default width localparams.
- Sub-module nn_mac: signed multiply-accumulate with clear and enable, parametrised PIX_W/WGT_W/ACC_W.
- FSM, counters, scaling and argmax stay in nn_layer_engine.

## Test plan
- Params NUM_INPUTS=4, NUM_OUTPUTS=3, FRAC_BITS=0. Setup: pixels 1,2,3,4; weight rows [1,1,1,1], [2,0,0,0], [0,0,0,5]. Start -> writes res 10, 2, 20 at sel 0, 1, 2; argmax=2, max_value=20; done at cycle 19; busy high cycles 1-18.
- Setup: pixels all 32767; weights all 32767; RES_W=17. -> every res_data=65535, overflow=1.
- Setup: row 1 = [-1,-1,-1,-1], relu_en=1. -> res_data for sel 1 = 0; with relu_en=0 -> -10.
- Setup: rows producing equal maxima 7, 7, 3. -> argmax=0.
- Stimulus: rst asserted during second neuron's RUN. -> outputs at reset values next edge; no res_we for sel 1; new start then completes normally.
- Stimulus: start pulsed while busy. -> ignored, done count and latency unchanged.
